// File: rtl/axi4_pkg.sv
// Purpose: shared AXI4 encodings and helpers for the simbus AXI4 port family.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package axi4_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxSIZE encoding for a full-width beat: log2(bytes per beat).
  function automatic logic [2:0] size_of(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi4_skid_buf.sv
// Purpose: 2-entry valid/ready skid buffer, generic payload width.
// Latency: 1 cycle from input handshake to out_vld.
// Backpressure: in_rdy is a registered "not full", so upstream stalls the cycle after the 2nd entry fills.
//
// Ports: core_clk/arst_n clock and async active-low reset; in_vld/in_rdy/in_dat
// write side; out_vld/out_rdy/out_dat read side (head of buffer).
module axi4_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             rdy_q;
  logic             push;
  logic             pop;

  assign push    = in_vld & rdy_q;
  assign out_vld = (cnt_q != 2'd0);
  assign pop     = out_vld & out_rdy;
  assign in_rdy  = rdy_q;
  assign out_dat = mem[rd_ptr];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // rdy_q is held low through reset and rises on the first clock after
  // release; it tracks the next-cycle fill level so it is a clean flop output.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Payload storage needs no reset; validity is carried by cnt_q.
  always_ff @(posedge core_clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

endmodule

// File: rtl/axi4_read_master_port.sv
// Purpose: command stream -> AXI4 AR bursts, R beats -> buffered rsp stream, with in-order slave checking.
// Latency: cmd accept to ARVALID 1 cycle; R handshake to rsp_valid 1 cycle.
// Backpressure: cmd_ready low in ADDR or at MAX_OUTST in flight; RREADY drops 1 cycle after the R buffer fills.
//
// Ports: ACLK/ARESETn clock and async active-low reset; cmd_* command input;
// AR*/R* AXI4 read master channels; rsp_* buffered beat output; outst bursts
// in flight; err sticky protocol error (id/length/unexpected beat).
module axi4_read_master_port
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [7:0]                 cmd_len,
  input  logic [ID_WIDTH-1:0]        cmd_id,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  output logic [ADDR_WIDTH-1:0]      ARADDR,
  output logic [7:0]                 ARLEN,
  output logic [2:0]                 ARSIZE,
  output logic [1:0]                 ARBURST,
  output logic [ID_WIDTH-1:0]        ARID,
  input  logic                       RVALID,
  output logic                       RREADY,
  input  logic [DATA_WIDTH-1:0]      RDATA,
  input  logic [1:0]                 RRESP,
  input  logic [ID_WIDTH-1:0]        RID,
  input  logic                       RLAST,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_resp,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic                       rsp_last,
  output logic [$clog2(MAX_OUTST):0] outst,
  output logic                       err
);

  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {S_IDLE, S_ADDR} ar_state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          len;
  } exp_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
  } r_beat_t;

  ar_state_t       state_q;
  ar_state_t       state_d;
  logic            run_q;
  logic            cmd_acc;
  logic            r_hs;
  logic            exp_empty;
  logic            exp_pop;
  exp_t            exp_mem [MAX_OUTST];
  exp_t            exp_head;
  logic [PW-1:0]   exp_wp;
  logic [PW-1:0]   exp_rp;
  logic [7:0]      beat_cnt;
  r_beat_t         r_in;
  r_beat_t         r_out;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Keeps cmd_ready low while ARESETn is asserted and for the release edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // ---------------- AR channel FSM ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    ARVALID   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = run_q && (outst < OW'(MAX_OUTST));
        if (cmd_valid && cmd_ready) state_d = S_ADDR;
      end
      S_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_acc = cmd_valid & cmd_ready;
  assign ARSIZE  = size_of(DATA_WIDTH);
  assign ARBURST = BURST_INCR;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ARADDR <= '0;
      ARLEN  <= '0;
      ARID   <= '0;
    end else if (cmd_acc) begin
      ARADDR <= cmd_addr;
      ARLEN  <= cmd_len;
      ARID   <= cmd_id;
    end
  end

  // ---------------- Expect FIFO ----------------
  // Its occupancy is exactly the number of bursts in flight, so outst doubles
  // as the FIFO count. A stray RLAST with nothing expected is flagged by the
  // checker but does not underflow the count.
  assign r_hs      = RVALID & RREADY;
  assign exp_empty = (outst == '0);
  assign exp_pop   = r_hs & RLAST & ~exp_empty;
  assign exp_head  = exp_mem[exp_rp];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      exp_wp <= '0;
      exp_rp <= '0;
      outst  <= '0;
    end else begin
      if (cmd_acc) exp_wp <= ptr_inc(exp_wp);
      if (exp_pop) exp_rp <= ptr_inc(exp_rp);
      case ({cmd_acc, exp_pop})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (cmd_acc) exp_mem[exp_wp] <= '{id: cmd_id, len: cmd_len};
  end

  // ---------------- In-order burst checker ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (r_hs) begin
      beat_cnt <= RLAST ? 8'd0 : beat_cnt + 8'd1;
      if (exp_empty) begin
        err <= 1'b1;
      end else if ((RID != exp_head.id) || (RLAST != (beat_cnt == exp_head.len))) begin
        err <= 1'b1;
      end
    end
  end

  // ---------------- R buffer ----------------
  assign r_in = '{data: RDATA, resp: RRESP, id: RID, last: RLAST};

  axi4_skid_buf #(
    .WIDTH($bits(r_beat_t))
  ) u_r_buf (
    .core_clk (ACLK),
    .arst_n   (ARESETn),
    .in_vld   (RVALID),
    .in_rdy   (RREADY),
    .in_dat   (r_in),
    .out_vld  (rsp_valid),
    .out_rdy  (rsp_ready),
    .out_dat  (r_out)
  );

  assign rsp_data = r_out.data;
  assign rsp_resp = r_out.resp;
  assign rsp_id   = r_out.id;
  assign rsp_last = r_out.last;

endmodule

// File: tb/tb_axi4_read_master_port.sv
// Purpose: directed self-checking bench for axi4_read_master_port (default parameters).
// Latency: inputs driven 1 time unit after ACLK rise, outputs sampled at the same point.
// Backpressure: rsp_ready patterns exercise the R buffer stall path.
module tb_axi4_read_master_port;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARID;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic [3:0]  RID;
  logic        RLAST;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_id;
  logic        rsp_last;
  logic [2:0]  outst;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  axi4_read_master_port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MAX_OUTST(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .RID(RID), .RLAST(RLAST),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_id(rsp_id), .rsp_last(rsp_last),
    .outst(outst), .err(err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one command and waits (bounded) for acceptance.
  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [3:0] i);
    int n;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_id    = i;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [3:0] i, input logic l);
    RVALID = 1'b1;
    RDATA  = d;
    RID    = i;
    RLAST  = l;
    RRESP  = 2'b00;
  endtask

  initial begin
    int k, j, mc;
    logic rh, ph;
    ARESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_id    = '0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RDATA     = '0;
    RRESP     = '0;
    RID       = '0;
    RLAST     = 1'b0;
    rsp_ready = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outst", outst, 0);
    chk("rst_err", err, 0);
    chk("rst_araddr", ARADDR, 0);
    ARESETn = 1'b1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_rready", RREADY, 1);

    // ---- single read, ARREADY after 2 cycles ----
    send_cmd(32'h100, 8'd3, 4'd2);
    chk("t1_arvalid", ARVALID, 1);
    chk("t1_araddr", ARADDR, 32'h100);
    chk("t1_arlen", ARLEN, 3);
    chk("t1_arsize", ARSIZE, 2);
    chk("t1_arburst", ARBURST, 1);
    chk("t1_arid", ARID, 2);
    chk("t1_outst1", outst, 1);
    chk("t1_cmd_ready_addr", cmd_ready, 0);
    tick();
    chk("t1_arvalid_hold", ARVALID, 1);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("t1_arvalid_drop", ARVALID, 0);
    for (int b = 0; b < 4; b++) begin
      r_beat(32'hA0 + b, 4'd2, b == 3);
      tick();
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_data", rsp_data, 32'hA0 + b);
      chk("t1_rsp_id", rsp_id, 2);
      chk("t1_rsp_last", rsp_last, b == 3);
    end
    RVALID = 1'b0;
    chk("t1_outst0", outst, 0);
    tick();
    chk("t1_rsp_empty", rsp_valid, 0);
    chk("t1_err", err, 0);

    // ---- outstanding limit ----
    ARREADY = 1'b1;
    for (int c = 0; c < 4; c++) send_cmd(32'h1000 + 32'(c) * 32'h40, 8'd0, 4'(c));
    tick();
    chk("t2_outst4", outst, 4);
    chk("t2_cmd_ready_full", cmd_ready, 0);
    chk("t2_arvalid_idle", ARVALID, 0);
    cmd_addr  = 32'h1100;
    cmd_len   = 8'd0;
    cmd_id    = 4'd4;
    cmd_valid = 1'b1;
    tick();
    tick();
    chk("t2_stall_ready", cmd_ready, 0);
    chk("t2_stall_outst", outst, 4);
    r_beat(32'h10, 4'd0, 1'b1);
    tick();
    RVALID = 1'b0;
    chk("t2_outst3", outst, 3);
    chk("t2_cmd_ready_free", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t2_outst_refill", outst, 4);
    chk("t2_arvalid5", ARVALID, 1);
    chk("t2_arid5", ARID, 4);
    tick();
    for (int c = 1; c < 5; c++) begin
      r_beat(32'h10 + c, 4'(c), 1'b1);
      tick();
    end
    RVALID = 1'b0;
    chk("t2_outst_drain", outst, 0);
    chk("t2_err", err, 0);
    tick();
    tick();

    // ---- backpressure, 8-beat burst, rsp_ready 1,0,0,1 ----
    send_cmd(32'h2000, 8'd7, 4'd5);
    tick();
    k  = 0;
    j  = 0;
    mc = 0;
    for (int c = 0; c < 60 && j < 8; c++) begin
      rsp_ready = (c % 4 == 0) || (c % 4 == 3);
      if (k < 8) r_beat(32'hB0 + k, 4'd5, k == 7);
      else       RVALID = 1'b0;
      chk("t3_rready", RREADY, mc != 2);
      rh = RVALID && RREADY;
      ph = rsp_valid && rsp_ready;
      if (ph) begin
        chk("t3_rsp_data", rsp_data, 32'hB0 + j);
        chk("t3_rsp_last", rsp_last, j == 7);
        j++;
      end
      tick();
      if (rh) begin
        k++;
        mc++;
      end
      if (ph) mc--;
    end
    RVALID    = 1'b0;
    rsp_ready = 1'b1;
    chk("t3_delivered", j, 8);
    tick();
    chk("t3_no_dup", rsp_valid, 0);
    chk("t3_outst", outst, 0);
    chk("t3_err", err, 0);

    // ---- length error: len=1 but RLAST on first beat ----
    send_cmd(32'h200, 8'd1, 4'd6);
    tick();
    r_beat(32'hC0, 4'd6, 1'b1);
    tick();
    RVALID = 1'b0;
    chk("t4_err", err, 1);
    chk("t4_fwd_valid", rsp_valid, 1);
    chk("t4_fwd_data", rsp_data, 32'hC0);
    chk("t4_fwd_last", rsp_last, 1);
    chk("t4_outst", outst, 0);
    tick();
    chk("t4_err_sticky", err, 1);

    // ---- reset mid-burst ----
    send_cmd(32'h300, 8'd3, 4'd7);
    tick();
    r_beat(32'hD0, 4'd7, 1'b0);
    tick();
    r_beat(32'hD1, 4'd7, 1'b0);
    tick();
    r_beat(32'hD2, 4'd7, 1'b0);
    ARESETn = 1'b0;
    #1;
    RVALID = 1'b0;
    chk("t6_arvalid", ARVALID, 0);
    chk("t6_rready", RREADY, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    chk("t6_outst", outst, 0);
    chk("t6_err", err, 0);
    chk("t6_arlen", ARLEN, 0);
    tick();
    ARESETn = 1'b1;
    tick();
    chk("t6_rsp_after", rsp_valid, 0);
    send_cmd(32'h400, 8'd0, 4'd3);
    tick();
    r_beat(32'hE0, 4'd3, 1'b1);
    tick();
    RVALID = 1'b0;
    chk("t6_new_valid", rsp_valid, 1);
    chk("t6_new_data", rsp_data, 32'hE0);
    chk("t6_new_id", rsp_id, 3);
    chk("t6_new_err", err, 0);
    chk("t6_new_outst", outst, 0);
    tick();

    // ---- id error: issue id=1 then id=3, slave answers id=3 first ----
    send_cmd(32'h500, 8'd0, 4'd1);
    send_cmd(32'h600, 8'd0, 4'd3);
    tick();
    chk("t5_outst2", outst, 2);
    r_beat(32'hF3, 4'd3, 1'b1);
    tick();
    RVALID = 1'b0;
    chk("t5_err", err, 1);
    chk("t5_fwd_id", rsp_id, 3);
    chk("t5_outst1", outst, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
